// File: rtl/eth_pcs_params.sv
// eth_pcs_params: shared constants, defaults and lane state type for the
// 64b/66b RX block synchroniser.
package eth_pcs_params;

    localparam int W_SYNC = 2;
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam int DEF_SH_TH       = 64;
    localparam int DEF_SH_INVAL_TH = 16;
    localparam int DEF_SLIP_WAIT   = 4;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } lane_state_e;

    // Counter width able to hold maxVal; never narrower than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/eth_pcs_rx_block_sync_lane.sv
// eth_pcs_rx_block_sync_lane: one lane's HUNT/SLIP_WAIT/LOCKED sync-header FSM.
// ETH_PCS_BLK_SYNC_STATS_EN adds a 16-bit saturating invalid-header counter.
module eth_pcs_rx_block_sync_lane
    import eth_pcs_params::*;
#(
    parameter int SH_TH       = DEF_SH_TH,
    parameter int SH_INVAL_TH = DEF_SH_INVAL_TH,
    parameter int SLIP_WAIT   = DEF_SLIP_WAIT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [W_SYNC-1:0] i_sync_hdr,
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
    input  logic              i_stats_clr,
    output logic [15:0]       o_inval_cnt,
`endif
    output logic              o_slip,
    output logic              o_rx_lock,
    output logic              o_lock_lost
);

    localparam int SH_W    = cntWidth(SH_TH);
    localparam int INVAL_W = cntWidth(SH_INVAL_TH);
    localparam int WAIT_W  = cntWidth(SLIP_WAIT);

    lane_state_e          state_q, state_d;
    logic [SH_W-1:0]      shCnt_q, shCnt_d;
    logic [INVAL_W-1:0]   invalCnt_q, invalCnt_d;
    logic [WAIT_W-1:0]    waitCnt_q, waitCnt_d;
    logic                 slip_q, slip_d;
    logic                 lockLost_q, lockLost_d;

    logic                 hdrValid;
    logic [SH_W-1:0]      shNext;
    logic [INVAL_W-1:0]   invalNext;
    logic [WAIT_W-1:0]    waitNext;

    assign hdrValid  = (i_sync_hdr == SYNC_DATA) || (i_sync_hdr == SYNC_CTRL);
    assign shNext    = shCnt_q + SH_W'(1);
    assign invalNext = invalCnt_q + (hdrValid ? INVAL_W'(0) : INVAL_W'(1));
    assign waitNext  = waitCnt_q + WAIT_W'(1);

    always_comb begin
        state_d    = state_q;
        shCnt_d    = shCnt_q;
        invalCnt_d = invalCnt_q;
        waitCnt_d  = waitCnt_q;
        slip_d     = 1'b0;
        lockLost_d = 1'b0;
        if (i_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (hdrValid) begin
                        if (shNext == SH_W'(SH_TH)) begin
                            state_d    = ST_LOCKED;
                            shCnt_d    = '0;
                            invalCnt_d = '0;
                        end else begin
                            shCnt_d = shNext;
                        end
                    end else begin
                        slip_d    = 1'b1;
                        shCnt_d   = '0;
                        waitCnt_d = '0;
                        if (SLIP_WAIT == 0) state_d = ST_HUNT;
                        else                state_d = ST_SLIP_WAIT;
                    end
                end
                // Headers are meaningless while the gearbox realigns; only beats count.
                ST_SLIP_WAIT: begin
                    if (waitNext == WAIT_W'(SLIP_WAIT)) begin
                        state_d    = ST_HUNT;
                        waitCnt_d  = '0;
                        shCnt_d    = '0;
                        invalCnt_d = '0;
                    end else begin
                        waitCnt_d = waitNext;
                    end
                end
                ST_LOCKED: begin
                    if (!hdrValid && (invalNext == INVAL_W'(SH_INVAL_TH))) begin
                        slip_d     = 1'b1;
                        lockLost_d = 1'b1;
                        shCnt_d    = '0;
                        invalCnt_d = '0;
                        waitCnt_d  = '0;
                        if (SLIP_WAIT == 0) state_d = ST_HUNT;
                        else                state_d = ST_SLIP_WAIT;
                    end else if (shNext == SH_W'(SH_TH)) begin
                        shCnt_d    = '0;
                        invalCnt_d = '0;
                    end else begin
                        shCnt_d    = shNext;
                        invalCnt_d = invalNext;
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    shCnt_d    = '0;
                    invalCnt_d = '0;
                    waitCnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_HUNT;
            shCnt_q    <= '0;
            invalCnt_q <= '0;
            waitCnt_q  <= '0;
            slip_q     <= 1'b0;
            lockLost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shCnt_q    <= shCnt_d;
            invalCnt_q <= invalCnt_d;
            waitCnt_q  <= waitCnt_d;
            slip_q     <= slip_d;
            lockLost_q <= lockLost_d;
        end
    end

    assign o_slip      = slip_q;
    assign o_lock_lost = lockLost_q;
    assign o_rx_lock   = (state_q == ST_LOCKED);

`ifdef ETH_PCS_BLK_SYNC_STATS_EN
    logic [15:0] statCnt_q, statCnt_d;

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        statCnt_d = statCnt_q;
        if (i_stats_clr) begin
            statCnt_d = '0;
        end else if (i_valid && !hdrValid && (state_q != ST_SLIP_WAIT)
                     && (statCnt_q != 16'hFFFF)) begin
            statCnt_d = statCnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) statCnt_q <= '0;
        else         statCnt_q <= statCnt_d;
    end

    assign o_inval_cnt = statCnt_q;
`endif

endmodule

// File: rtl/eth_pcs_rx_block_sync_mlane.sv
// eth_pcs_rx_block_sync_mlane: NUM_LANES independent 64b/66b block synchronisers
// plus aggregate lock. ETH_PCS_BLK_SYNC_STATS_EN adds per-lane invalid-header counters.
module eth_pcs_rx_block_sync_mlane
    import eth_pcs_params::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int SH_TH       = DEF_SH_TH,
    parameter int SH_INVAL_TH = DEF_SH_INVAL_TH,
    parameter int SLIP_WAIT   = DEF_SLIP_WAIT
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_LANES-1:0]        i_valid,
    input  logic [NUM_LANES*W_SYNC-1:0] i_sync_hdr,
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
    input  logic                        i_stats_clr,
    output logic [NUM_LANES*16-1:0]     o_inval_cnt,
`endif
    output logic [NUM_LANES-1:0]        o_slip,
    output logic [NUM_LANES-1:0]        o_rx_lock,
    output logic                        o_all_lock,
    output logic [NUM_LANES-1:0]        o_lock_lost
);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        eth_pcs_rx_block_sync_lane #(
            .SH_TH       (SH_TH),
            .SH_INVAL_TH (SH_INVAL_TH),
            .SLIP_WAIT   (SLIP_WAIT)
        ) u_lane (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_valid     (i_valid[n]),
            .i_sync_hdr  (i_sync_hdr[n*W_SYNC +: W_SYNC]),
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
            .i_stats_clr (i_stats_clr),
            .o_inval_cnt (o_inval_cnt[n*16 +: 16]),
`endif
            .o_slip      (o_slip[n]),
            .o_rx_lock   (o_rx_lock[n]),
            .o_lock_lost (o_lock_lost[n])
        );
    end

    // Deskew waits on every lane, so aggregate lock is a plain AND of registered locks.
    assign o_all_lock = &o_rx_lock;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync_mlane.sv
// tb_eth_pcs_rx_block_sync_mlane: scenario tasks plus randomized traffic checked
// against a counter/hold-off reference model. ETH_PCS_BLK_SYNC_STATS_EN enables stats checks.
module tb_eth_pcs_rx_block_sync_mlane;
    import eth_pcs_params::*;

    localparam int NL  = 4;
    localparam int TH  = 64;
    localparam int INV = 16;
    localparam int SW  = 4;

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b0;
    logic [NL-1:0]        i_valid = '0;
    logic [NL*W_SYNC-1:0] i_sync_hdr = '0;
    logic [NL-1:0]        o_slip, o_rx_lock, o_lock_lost;
    logic                 o_all_lock;

    int total = 0;
    int bad   = 0;

    // Reference model: locked flag, remaining hold-off beats, window/run count, bad count.
    int mLocked [NL];
    int mHold   [NL];
    int mCnt    [NL];
    int mBad    [NL];
    logic [NL-1:0] expSlip, expLost, expLock;

`ifdef ETH_PCS_BLK_SYNC_STATS_EN
    logic               i_stats_clr = 1'b0;
    logic [NL*16-1:0]   o_inval_cnt;
    int                 mStat [NL];

    logic       sValid = 1'b0;
    logic [1:0] sHdr = 2'b00;
    logic       sClr = 1'b0;
    logic       sSlip, sLock, sAll, sLost;
    logic [15:0] sCnt;

    eth_pcs_rx_block_sync_mlane #(
        .NUM_LANES(1), .SH_TH(TH), .SH_INVAL_TH(INV), .SLIP_WAIT(0)
    ) u_stats (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (sValid),
        .i_sync_hdr  (sHdr),
        .i_stats_clr (sClr),
        .o_inval_cnt (sCnt),
        .o_slip      (sSlip),
        .o_rx_lock   (sLock),
        .o_all_lock  (sAll),
        .o_lock_lost (sLost)
    );
`endif

    eth_pcs_rx_block_sync_mlane #(
        .NUM_LANES(NL), .SH_TH(TH), .SH_INVAL_TH(INV), .SLIP_WAIT(SW)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_sync_hdr  (i_sync_hdr),
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
        .i_stats_clr (i_stats_clr),
        .o_inval_cnt (o_inval_cnt),
`endif
        .o_slip      (o_slip),
        .o_rx_lock   (o_rx_lock),
        .o_all_lock  (o_all_lock),
        .o_lock_lost (o_lock_lost)
    );

    always #5 i_clk = ~i_clk;

    task automatic modelReset();
        for (int n = 0; n < NL; n++) begin
            mLocked[n] = 0; mHold[n] = 0; mCnt[n] = 0; mBad[n] = 0;
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
            mStat[n] = 0;
`endif
        end
        expSlip = '0; expLost = '0; expLock = '0;
    endtask

    task automatic modelLane(input int n, input logic v, input logic [1:0] h);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        expSlip[n] = 1'b0;
        expLost[n] = 1'b0;
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
        if (i_stats_clr) mStat[n] = 0;
        else if (v && !good && mHold[n] == 0 && mStat[n] < 65535) mStat[n]++;
`endif
        if (v) begin
            if (mHold[n] > 0) begin
                mHold[n]--;
            end else if (mLocked[n] == 0) begin
                if (good) begin
                    mCnt[n]++;
                    if (mCnt[n] == TH) begin mLocked[n] = 1; mCnt[n] = 0; mBad[n] = 0; end
                end else begin
                    expSlip[n] = 1'b1; mCnt[n] = 0; mHold[n] = SW;
                end
            end else begin
                mCnt[n]++;
                if (!good) mBad[n]++;
                if (mBad[n] == INV) begin
                    expSlip[n] = 1'b1; expLost[n] = 1'b1;
                    mLocked[n] = 0; mCnt[n] = 0; mBad[n] = 0; mHold[n] = SW;
                end else if (mCnt[n] == TH) begin
                    mCnt[n] = 0; mBad[n] = 0;
                end
            end
        end
        expLock[n] = (mLocked[n] != 0);
    endtask

    task automatic step(input logic [NL-1:0] v, input logic [NL*W_SYNC-1:0] h);
        i_valid    = v;
        i_sync_hdr = h;
        @(posedge i_clk);
        for (int n = 0; n < NL; n++) modelLane(n, v[n], h[n*W_SYNC +: W_SYNC]);
        #1;
    endtask

    task automatic doReset();
        i_reset    = 1'b1;
        i_valid    = '1;
        i_sync_hdr = {NL{2'b11}};
        @(posedge i_clk);
        modelReset();
        #1;
        i_reset = 1'b0;
        i_valid = '0;
    endtask

    function automatic logic [NL*W_SYNC-1:0] hdrBus(input logic [1:0] allLanes,
                                                    input int lane, input logic [1:0] laneHdr);
        logic [NL*W_SYNC-1:0] r;
        for (int n = 0; n < NL; n++) r[n*W_SYNC +: W_SYNC] = (n == lane) ? laneHdr : allLanes;
        return r;
    endfunction

    task automatic test_reset();
        step('1, {NL{2'b01}});
        doReset();
        total++;
        if ({o_slip, o_lock_lost, o_rx_lock, o_all_lock} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state got=%b required=0", {o_slip, o_lock_lost, o_rx_lock, o_all_lock});
        end
    endtask

    task automatic test_clean_lock();
        logic [NL-1:0] want;
        doReset();
        for (int i = 1; i <= TH; i++) begin
            step('1, {NL{2'b01}});
            want = (i == TH) ? {NL{1'b1}} : {NL{1'b0}};
            total++;
            if ({o_slip, o_lock_lost, o_rx_lock, o_all_lock} !== {{NL{1'b0}}, {NL{1'b0}}, want, &want}) begin
                bad++;
                $display("[TB] FAIL clean_lock beat=%0d slip=%b lost=%b lock=%b all=%b required lock=%b",
                         i, o_slip, o_lock_lost, o_rx_lock, o_all_lock, want);
            end
        end
    endtask

    task automatic test_hunt_slip();
        logic [NL-1:0] want;
        doReset();
        for (int i = 0; i < 7; i++) begin
            step('1, hdrBus(2'b01, 1, (i == 0) ? 2'b11 : 2'b00));
            want = (i == 0 || i == 5) ? 4'b0010 : 4'b0000;
            total++;
            if (o_slip !== want || o_rx_lock !== '0) begin
                bad++;
                $display("[TB] FAIL hunt_slip beat=%0d slip=%b required=%b lock=%b", i, o_slip, want, o_rx_lock);
            end
        end
    endtask

    task automatic test_window();
        logic [NL-1:0] wantS, wantL;
        doReset();
        for (int i = 0; i < TH; i++) step('1, {NL{2'b01}});
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < TH; i++) begin
                step('1, hdrBus(2'b01, 2, ((i % 4 == 0) && (w == 1 || i < 60)) ? 2'b00 : 2'b01));
                wantS = (w == 1 && i == 60) ? 4'b0100 : 4'b0000;
                wantL = (w == 1 && i >= 60) ? 4'b1011 : 4'b1111;
                total++;
                if ({o_slip, o_lock_lost, o_rx_lock, o_all_lock} !== {wantS, wantS, wantL, &wantL}) begin
                    bad++;
                    $display("[TB] FAIL window w=%0d i=%0d slip=%b lost=%b lock=%b all=%b required slip=lost=%b lock=%b",
                             w, i, o_slip, o_lock_lost, o_rx_lock, o_all_lock, wantS, wantL);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [NL-1:0] wantS, wantL;
        doReset();
        for (int i = 0; i < TH; i++) step('1, {NL{2'b01}});
        for (int i = 0; i < TH; i++) begin
            step('1, hdrBus(2'b10, 0, (i >= TH - INV) ? 2'b11 : 2'b10));
            wantS = (i == TH - 1) ? 4'b0001 : 4'b0000;
            wantL = (i == TH - 1) ? 4'b1110 : 4'b1111;
            total++;
            if ({o_slip, o_lock_lost, o_rx_lock} !== {wantS, wantS, wantL}) begin
                bad++;
                $display("[TB] FAIL simultaneous i=%0d slip=%b lost=%b lock=%b required slip=lost=%b lock=%b",
                         i, o_slip, o_lock_lost, o_rx_lock, wantS, wantL);
            end
        end
    endtask

    task automatic test_valid_gaps();
        int beats;
        logic [NL-1:0] want;
        doReset();
        beats = 0;
        for (int k = 0; k < 2 * TH + 4; k++) begin
            if (k % 2 == 1) begin
                step('1, {NL{2'b01}});
                beats++;
            end else begin
                step('0, {NL{2'b00}});
            end
            want = (beats >= TH) ? {NL{1'b1}} : {NL{1'b0}};
            total++;
            if ({o_slip, o_lock_lost, o_rx_lock} !== {{NL{1'b0}}, {NL{1'b0}}, want}) begin
                bad++;
                $display("[TB] FAIL valid_gaps k=%0d beats=%0d slip=%b lock=%b required lock=%b",
                         k, beats, o_slip, o_rx_lock, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < TH; i++) step('1, {NL{2'b01}});
        doReset();
        total++;
        if ({o_slip, o_lock_lost, o_rx_lock, o_all_lock} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_locked got=%b required=0", {o_slip, o_lock_lost, o_rx_lock, o_all_lock});
        end
        for (int r = 0; r < 2; r++) begin
            step('1, hdrBus(2'b01, 3, 2'b11));
            total++;
            if (o_slip !== 4'b1000) begin
                bad++;
                $display("[TB] FAIL reset_mid_slip round=%0d slip=%b required=1000", r, o_slip);
            end
            if (r == 0) doReset();
        end
    endtask

    task automatic test_random();
        int rate [NL];
        logic [NL-1:0] v;
        logic [NL*W_SYNC-1:0] h;
        doReset();
        for (int seg = 0; seg < 8; seg++) begin
            for (int n = 0; n < NL; n++) rate[n] = (seg % 2 == 0) ? 5 : 100 + n * 80;
            for (int c = 0; c < 400; c++) begin
                for (int n = 0; n < NL; n++) begin
                    v[n] = ($urandom_range(0, 9) != 0);
                    if ($urandom_range(0, 999) < rate[n])
                        h[n*W_SYNC +: W_SYNC] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
                    else
                        h[n*W_SYNC +: W_SYNC] = ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL;
                end
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
                i_stats_clr = ($urandom_range(0, 299) == 0);
`endif
                step(v, h);
                total++;
                if ({o_slip, o_lock_lost, o_rx_lock, o_all_lock} !== {expSlip, expLost, expLock, &expLock}) begin
                    bad++;
                    $display("[TB] FAIL random seg=%0d c=%0d slip=%b lost=%b lock=%b all=%b required slip=%b lost=%b lock=%b",
                             seg, c, o_slip, o_lock_lost, o_rx_lock, o_all_lock, expSlip, expLost, expLock);
                end
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
                for (int n = 0; n < NL; n++) begin
                    total++;
                    if (o_inval_cnt[n*16 +: 16] !== 16'(mStat[n])) begin
                        bad++;
                        $display("[TB] FAIL random_stats lane=%0d got=%0d required=%0d",
                                 n, o_inval_cnt[n*16 +: 16], mStat[n]);
                    end
                end
`endif
            end
        end
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
        i_stats_clr = 1'b0;
`endif
    endtask

`ifdef ETH_PCS_BLK_SYNC_STATS_EN
    task automatic test_stats();
        doReset();
        sValid = 1'b1;
        sHdr   = 2'b11;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge i_clk);
            #1;
            if (i == 65534 || i == 65535 || i == 70000) begin
                total++;
                if (sCnt !== ((i == 65534) ? 16'd65534 : 16'hFFFF) || sSlip !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL stats_saturate beat=%0d cnt=%0d slip=%b required cnt=%0d slip=1",
                             i, sCnt, sSlip, (i == 65534) ? 65534 : 65535);
                end
            end
        end
        sClr = 1'b1;
        @(posedge i_clk);
        #1;
        sClr = 1'b0;
        total++;
        if (sCnt !== 16'd0) begin
            bad++;
            $display("[TB] FAIL stats_clear cnt=%0d required=0", sCnt);
        end
        @(posedge i_clk);
        #1;
        sValid = 1'b0;
        total++;
        if (sCnt !== 16'd1) begin
            bad++;
            $display("[TB] FAIL stats_after_clear cnt=%0d required=1", sCnt);
        end
    endtask
`endif

    initial begin
        modelReset();
        test_reset();
        test_clean_lock();
        test_hunt_slip();
        test_window();
        test_simultaneous();
        test_valid_gaps();
        test_reset_mid();
        test_random();
`ifdef ETH_PCS_BLK_SYNC_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_pcs_rx_block_sync_mlane.md
# eth_pcs_rx_block_sync_mlane

Multi-lane 64b/66b block synchroniser for the Ethernet PCS receive path, parametrised in lane count and lock thresholds. Each lane runs an independent HUNT/SLIP_WAIT/LOCKED state machine on incoming 2-bit sync headers and issues slip requests to its upstream gearbox. Each slip is followed by a configurable hold-off so the gearbox can realign before headers are judged again. Sits between the per-lane RX gearboxes and lane deskew/descrambler; the aggregate lock gates deskew.

## Interface
- NUM_LANES, 4, number of independent lanes (1 gives single-lane 10GBASE-R use)
- SH_TH, 64, headers per lock/monitor window
- SH_INVAL_TH, 16, invalid headers within a window that cause loss of lock
- SLIP_WAIT, 4, valid beats ignored after each slip (0 = no hold-off)
- i_clk  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk
- i_valid  in  NUM_LANES  per-lane header-valid strobe
- i_sync_hdr  in  NUM_LANES*W_SYNC  per-lane sync header; lane n at bits [n*W_SYNC +: W_SYNC]
- o_slip  out  NUM_LANES  per-lane one-cycle slip request
- o_rx_lock  out  NUM_LANES  per-lane block lock
- o_all_lock  out  1  AND of o_rx_lock
- o_lock_lost  out  NUM_LANES  one-cycle pulse when a lane leaves LOCKED

## Operation
- Valid header: SYNC_DATA (2'b01) or SYNC_CTRL (2'b10). 2'b00 and 2'b11 are invalid.
- A lane only evaluates a header on a beat with i_valid[n]=1. With i_valid[n]=0, that lane's state and counters hold.
- Counters: sh_cnt has width $clog2(SH_TH+1); inval_cnt has width $clog2(SH_INVAL_TH+1); wait_cnt has width $clog2(SLIP_WAIT+1).
- HUNT:
  - Valid header: sh_cnt+1. When sh_cnt reaches SH_TH, go to LOCKED and clear both counters.
  - Invalid header: slip, clear sh_cnt, go to SLIP_WAIT.
- SLIP_WAIT:
  - Headers are ignored; wait_cnt counts valid beats.
  - After SLIP_WAIT beats, return to HUNT with counters cleared.
  - With SLIP_WAIT=0, a slip goes directly to HUNT.
- LOCKED:
  - Every header increments sh_cnt; an invalid header also increments inval_cnt.
  - When inval_cnt reaches SH_INVAL_TH: slip, pulse o_lock_lost, go to SLIP_WAIT, clear counters.
  - Otherwise, when sh_cnt reaches SH_TH, clear both counters and stay in LOCKED.
- Simultaneous events: if the SH_TH-th header of a window is also the SH_INVAL_TH-th invalid header, loss of lock wins.
- Lanes are fully independent; no cross-lane interaction except o_all_lock.

## Timing
- Reset values: all lanes in HUNT, all counters 0, o_slip=0, o_rx_lock=0, o_all_lock=0, o_lock_lost=0.
- Reset asserted mid-operation: next cycle matches the reset values. A pending slip or hold-off is discarded.
- Header accepted at edge t, i.e. i_valid=1 during the cycle before t:
  - o_slip and o_lock_lost are high for exactly the cycle after edge t.
  - o_rx_lock updates after edge t.
  - Latency is 1 cycle.
- o_all_lock is combinational from the registered o_rx_lock (no added latency).
- Minimum spacing between slips on one lane is SLIP_WAIT+1 valid beats.
- Clean input after reset: o_rx_lock rises one cycle after the SH_TH-th valid header.

## Configuration
- Macro: ETH_PCS_BLK_SYNC_STATS_EN.
- When defined, each lane adds a 16-bit saturating invalid-header counter:
  - Counts every invalid header on a valid beat, in any state except SLIP_WAIT.
  - Extra ports: i_stats_clr (in, 1) and o_inval_cnt (out, NUM_LANES*16).
  - i_stats_clr is synchronous and takes priority over a same-cycle increment (result 0).
  - Counters stick at 16'hFFFF.
  - Reset value is 0.
- When undefined, these ports and counters do not exist; lock behaviour is identical.

## Structure
- eth_pcs_params package holds:
  - SYNC_DATA, SYNC_CTRL, W_SYNC.
  - Default SH_TH, SH_INVAL_TH, SLIP_WAIT.
  - The lane state enum typedef (HUNT, SLIP_WAIT, LOCKED).
- Sub-module eth_pcs_rx_block_sync_lane holds one lane's FSM, counters and optional stats counter. The top level generates NUM_LANES instances, slices the header bus, and forms o_all_lock.

## Test plan
- Reset, then 64 valid headers 2'b01 on all lanes: o_rx_lock rises one cycle after the 64th, o_all_lock rises with it, o_slip never asserts.
- Lane 1 hunting receives 2'b11: o_slip[1] pulses once. The next 4 valid beats of 2'b00 produce no slip. The 5th invalid header slips again.
- Locked lane, window of 64 with 15 invalid headers: stays locked and the counters clear. The next window with 16 invalid headers: o_lock_lost and o_slip pulse together, o_rx_lock falls, other lanes unaffected.
- The 64th header of a window is the 16th invalid: loss of lock is taken, not a window reset.
- i_valid toggled 0/1 in a locked stream: lock only after 64 valid beats; an invalid header presented with i_valid=0 is ignored.
- Stats build: 70000 invalid headers in HUNT with SLIP_WAIT=0 saturate o_inval_cnt at 65535. i_stats_clr asserted on the same cycle as an invalid header yields 0.
